preco: RTL and testbench

Price calculator for the digital-scale datapath. It multiplies the measured weight by the unit price and presents a saturated 16-bit total price, plus an overflow flag. It sits between the weight-conditioning block and the display/formatter, and recomputes continuously: every clock edge accepts a new operand pair.

---
 rtl/preco.sv | 70 +++++++
 tb/tb_preco.sv | 134 +++++++++++++
 2 files changed

// File: rtl/preco.sv
// Saturating 16x16 price multiplier: capture stage then multiply/saturate stage, 2-cycle latency.
// No backpressure: a new operand pair is accepted on every edge with in_valid high.
module preco (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] weight_kg,
  input  logic [15:0] price_per_kg,
  input  logic        in_valid,
  output logic [15:0] total_price,
  output logic        overflow,
  output logic        out_valid
);

  logic [15:0] weight_q, weight_d;
  logic [15:0] price_q, price_d;
  logic        s1_vld_q, s1_vld_d;
  logic [15:0] total_q, total_d;
  logic        ovf_q, ovf_d;
  logic        out_vld_q, out_vld_d;
  logic [31:0] prod;

  always_comb begin
    weight_d  = weight_q;
    price_d   = price_q;
    s1_vld_d  = in_valid;
    total_d   = total_q;
    ovf_d     = ovf_q;
    out_vld_d = s1_vld_q;
    prod      = {16'd0, weight_q} * {16'd0, price_q};

    if (in_valid) begin
      weight_d = weight_kg;
      price_d  = price_per_kg;
    end

    // Result registers hold the last valid answer while the pipe is idle.
    if (s1_vld_q) begin
      if (prod[31:16] != 16'd0) begin
        total_d = 16'hFFFF;
        ovf_d   = 1'b1;
      end else begin
        total_d = prod[15:0];
        ovf_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      weight_q  <= 16'd0;
      price_q   <= 16'd0;
      s1_vld_q  <= 1'b0;
      total_q   <= 16'd0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      weight_q  <= weight_d;
      price_q   <= price_d;
      s1_vld_q  <= s1_vld_d;
      total_q   <= total_d;
      ovf_q     <= ovf_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign total_price = total_q;
  assign overflow    = ovf_q;
  assign out_valid   = out_vld_q;

endmodule

// File: tb/tb_preco.sv
// Directed bench for preco: reset, nominal, saturation boundaries, pipelining, valid gating, mid-stream reset.
module tb_preco;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] weight_kg;
  logic [15:0] price_per_kg;
  logic        in_valid;
  logic [15:0] total_price;
  logic        overflow;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;

  preco dut (
    .clk          (clk),
    .rst          (rst),
    .weight_kg    (weight_kg),
    .price_per_kg (price_per_kg),
    .in_valid     (in_valid),
    .total_price  (total_price),
    .overflow     (overflow),
    .out_valid    (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] w, input logic [15:0] p, input logic v);
    weight_kg    = w;
    price_per_kg = p;
    in_valid     = v;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] tp, input logic ov, input logic vl);
    check({tag, "_total"}, {16'd0, total_price}, {16'd0, tp});
    check({tag, "_ovf"},   {31'd0, overflow},    {31'd0, ov});
    check({tag, "_vld"},   {31'd0, out_valid},   {31'd0, vl});
  endtask

  initial begin
    rst = 1'b1;
    drive(16'h1234, 16'h4321, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      drive(16'($urandom), 16'($urandom), 1'($urandom));
    end
    expect_out("reset", 16'd0, 1'b0, 1'b0);

    rst = 1'b0;
    drive(16'd0, 16'd0, 1'b0);
    step();
    step();
    expect_out("idle", 16'd0, 1'b0, 1'b0);

    // Nominal: 500 * 20
    drive(16'd500, 16'd20, 1'b1);
    step();
    drive(16'd0, 16'd0, 1'b0);
    step();
    expect_out("nominal", 16'd10000, 1'b0, 1'b1);

    // Saturation boundaries, back to back
    drive(16'd255, 16'd257, 1'b1);
    step();
    drive(16'd256, 16'd256, 1'b1);
    step();
    expect_out("b255x257", 16'hFFFF, 1'b0, 1'b1);
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    step();
    expect_out("b256x256", 16'hFFFF, 1'b1, 1'b1);
    drive(16'd0, 16'd1234, 1'b1);
    step();
    expect_out("bmax", 16'hFFFF, 1'b1, 1'b1);

    // Zero operands and pipelining
    drive(16'd1234, 16'd0, 1'b1);
    step();
    expect_out("zero_w", 16'd0, 1'b0, 1'b1);
    drive(16'd3, 16'd7, 1'b1);
    step();
    expect_out("zero_p", 16'd0, 1'b0, 1'b1);
    drive(16'd10, 16'd10, 1'b1);
    step();
    expect_out("pipe3x7", 16'd21, 1'b0, 1'b1);

    // Valid gating: in_valid drops while inputs change to (99,99)
    drive(16'd99, 16'd99, 1'b0);
    step();
    expect_out("gate_e1", 16'd100, 1'b0, 1'b1);
    step();
    expect_out("gate_e2", 16'd100, 1'b0, 1'b0);
    step();
    expect_out("gate_e3", 16'd100, 1'b0, 1'b0);

    // Reset mid-stream discards (100,100)
    drive(16'd100, 16'd100, 1'b1);
    step();
    expect_out("pre_rst", 16'd100, 1'b0, 1'b0);
    rst = 1'b1;
    drive(16'd5, 16'd5, 1'b0);
    step();
    expect_out("mid_rst", 16'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    expect_out("post_rst", 16'd0, 1'b0, 1'b0);

    // First accepted pair after reset appears two edges later
    drive(16'd2, 16'd3, 1'b1);
    step();
    drive(16'd0, 16'd0, 1'b0);
    expect_out("after_rst_e1", 16'd0, 1'b0, 1'b0);
    step();
    expect_out("after_rst_e2", 16'd6, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
